// File: rtl/axi_pkg.sv
// Shared AXI encodings and FSM state types for the axi_full_s3 slave.
// Latency: none (declarations only).
// Backpressure: not applicable.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

endpackage

// File: rtl/axi_s3_addr_gen.sv
// Per-beat address engine: next address, memory index, range and burst checks.
// Latency: purely combinational.
// Backpressure: none; the owning FSM decides when to consume next_addr_o.
module axi_s3_addr_gen
    import axi_pkg::*;
#(
    parameter int                DATA_W    = 64,
    parameter int                ADDR_W    = 32,
    parameter int                MEM_DEPTH = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic [ADDR_W-1:0]            addr_i,
    input  logic [7:0]                   len_i,
    input  logic [2:0]                   size_i,
    input  logic [1:0]                   burst_i,
    input  logic [7:0]                   cnt_i,
    output logic [ADDR_W-1:0]            next_addr_o,
    output logic [$clog2(MEM_DEPTH)-1:0] idx_o,
    output logic                         oor_o,
    output logic                         burst_err_o,
    output logic                         last_o
);

    localparam int                SHIFT    = $clog2(DATA_W / 8);
    localparam int                IDX_W    = $clog2(MEM_DEPTH);
    localparam logic [2:0]        SIZE_MAX = 3'(SHIFT);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(MEM_DEPTH);

    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] word;
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] size_mask;
`ifdef AXI_S3_WRAP_EN
    logic [ADDR_W-1:0] wrap_len;
    logic [ADDR_W-1:0] wrap_mask;
`endif

    // Word index and range check for the beat currently addressed
    always_comb begin
        offset = addr_i - BASE_ADDR;
        word   = offset >> SHIFT;
        idx_o  = word[IDX_W-1:0];
        oor_o  = (addr_i < BASE_ADDR) || (word >= DEPTH_A);
        last_o = (cnt_i == len_i);
    end

    // Next beat address and whole-burst legality
    always_comb begin
        step        = ADDR_W'(1) << size_i;
        size_mask   = step - ADDR_W'(1);
        next_addr_o = addr_i;
        burst_err_o = (size_i > SIZE_MAX) || (burst_i == 2'b11);
`ifdef AXI_S3_WRAP_EN
        wrap_len  = ADDR_W'(len_i) + ADDR_W'(1);
        wrap_mask = (wrap_len << size_i) - ADDR_W'(1);
`endif
        case (burst_i)
            BURST_FIXED: next_addr_o = addr_i;
            BURST_INCR:  next_addr_o = addr_i + step;
            BURST_WRAP: begin
`ifdef AXI_S3_WRAP_EN
                // Stay inside the (len+1)*2^size window that holds the start address
                next_addr_o = (addr_i & ~wrap_mask) | ((addr_i + step) & wrap_mask);
                if (!(len_i inside {8'd1, 8'd3, 8'd7, 8'd15}) ||
                    ((addr_i & size_mask) != '0)) begin
                    burst_err_o = 1'b1;
                end
`else
                // Without wrap support the burst walks through with errors only
                next_addr_o = addr_i;
                burst_err_o = 1'b1;
`endif
            end
            default:     next_addr_o = addr_i;
        endcase
    end

`ifndef AXI_S3_WRAP_EN
    // size_mask only feeds the wrap alignment check
    logic unused_mask;
    assign unused_mask = ^size_mask;
`endif

endmodule

// File: rtl/axi_full_s3.sv
// AXI4 full slave over a word-addressed memory; optional WRAP via AXI_S3_WRAP_EN.
// Latency: first R beat one cycle after AR handshake, B one cycle after the wlast beat.
// Backpressure: R and B payloads hold while valid & !ready; AR/AW accepted only when idle.
module axi_full_s3
    import axi_pkg::*;
#(
    parameter int                DATA_W    = 64,
    parameter int                ADDR_W    = 32,
    parameter int                ID_W      = 4,
    parameter int                MEM_DEPTH = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    // read address
    input  logic [ADDR_W-1:0]     araddr,
    input  logic [ID_W-1:0]       arid,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic                  arvalid,
    output logic                  arready,
    // read data
    output logic [DATA_W-1:0]     rdata,
    output logic [ID_W-1:0]       rid,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,
    // write address
    input  logic [ADDR_W-1:0]     awaddr,
    input  logic [ID_W-1:0]       awid,
    input  logic [7:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    input  logic                  awvalid,
    output logic                  awready,
    // write data
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    // write response
    output logic [ID_W-1:0]       bid,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int NB    = DATA_W / 8;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // ---------------- read path state ----------------
    rd_state_e         r_state_q;
    logic              arready_q;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [ID_W-1:0]   rid_q;
    logic [1:0]        rresp_q;
    logic              rlast_q;
    logic [ADDR_W-1:0] raddr_q;   // address of the next beat to fetch
    logic [7:0]        rlen_q;
    logic [2:0]        rsize_q;
    logic [1:0]        rburst_q;
    logic [7:0]        rcnt_q;    // index of the next beat to fetch
    logic              rberr_q;

    logic [ADDR_W-1:0] r_ag_addr;
    logic [7:0]        r_ag_len;
    logic [2:0]        r_ag_size;
    logic [1:0]        r_ag_burst;
    logic [7:0]        r_ag_cnt;
    logic [ADDR_W-1:0] r_next;
    logic [IDX_W-1:0]  r_idx;
    logic              r_oor;
    logic              r_burst_err;
    logic              r_last;
    logic              r_fetch_err;
    logic [DATA_W-1:0] rdata_d;
    logic [1:0]        rresp_d;

    // ---------------- write path state ----------------
    wr_state_e         w_state_q;
    logic              awready_q;
    logic              wready_q;
    logic              bvalid_q;
    logic [ID_W-1:0]   bid_q;
    logic [1:0]        bresp_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [7:0]        wlen_q;
    logic [2:0]        wsize_q;
    logic [1:0]        wburst_q;
    logic [7:0]        wcnt_q;
    logic              wover_q;   // burst ran past len without wlast
    logic              wberr_q;   // whole-burst error, no memory access
    logic              werr_q;    // any beat so far erred

    logic [ADDR_W-1:0] w_ag_addr;
    logic [7:0]        w_ag_len;
    logic [2:0]        w_ag_size;
    logic [1:0]        w_ag_burst;
    logic [ADDR_W-1:0] w_next;
    logic [IDX_W-1:0]  w_idx;
    logic              w_oor;
    logic              w_burst_err;
    logic              w_last;
    logic              w_hs;
    logic              w_beat_err;
    logic              mem_we;

    // In idle the engines look at the incoming request, otherwise at the latched burst
    always_comb begin
        r_ag_addr  = (r_state_q == R_IDLE) ? araddr  : raddr_q;
        r_ag_len   = (r_state_q == R_IDLE) ? arlen   : rlen_q;
        r_ag_size  = (r_state_q == R_IDLE) ? arsize  : rsize_q;
        r_ag_burst = (r_state_q == R_IDLE) ? arburst : rburst_q;
        r_ag_cnt   = (r_state_q == R_IDLE) ? 8'd0    : rcnt_q;
        w_ag_addr  = (w_state_q == W_IDLE) ? awaddr  : waddr_q;
        w_ag_len   = (w_state_q == W_IDLE) ? awlen   : wlen_q;
        w_ag_size  = (w_state_q == W_IDLE) ? awsize  : wsize_q;
        w_ag_burst = (w_state_q == W_IDLE) ? awburst : wburst_q;
    end

    axi_s3_addr_gen #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH),
        .BASE_ADDR (BASE_ADDR)
    ) u_rd_ag (
        .addr_i      (r_ag_addr),
        .len_i       (r_ag_len),
        .size_i      (r_ag_size),
        .burst_i     (r_ag_burst),
        .cnt_i       (r_ag_cnt),
        .next_addr_o (r_next),
        .idx_o       (r_idx),
        .oor_o       (r_oor),
        .burst_err_o (r_burst_err),
        .last_o      (r_last)
    );

    axi_s3_addr_gen #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH),
        .BASE_ADDR (BASE_ADDR)
    ) u_wr_ag (
        .addr_i      (w_ag_addr),
        .len_i       (w_ag_len),
        .size_i      (w_ag_size),
        .burst_i     (w_ag_burst),
        .cnt_i       (wcnt_q),
        .next_addr_o (w_next),
        .idx_o       (w_idx),
        .oor_o       (w_oor),
        .burst_err_o (w_burst_err),
        .last_o      (w_last)
    );

    // Read beat fetch: errored beats return zero data
    always_comb begin
        r_fetch_err = ((r_state_q == R_IDLE) ? r_burst_err : rberr_q) || r_oor;
        rdata_d     = r_fetch_err ? '0 : mem[r_idx];
        rresp_d     = r_fetch_err ? RESP_SLVERR : RESP_OKAY;
    end

    // Read FSM: accept AR, stream beats, hold payload under backpressure
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rid_q     <= '0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rcnt_q    <= '0;
            rberr_q   <= 1'b0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (arvalid && arready_q) begin
                        arready_q <= 1'b0;
                        r_state_q <= R_DATA;
                        raddr_q   <= r_next;
                        rlen_q    <= arlen;
                        rsize_q   <= arsize;
                        rburst_q  <= arburst;
                        rcnt_q    <= 8'd1;
                        rberr_q   <= r_burst_err;
                        rid_q     <= arid;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= rdata_d;
                        rresp_q   <= rresp_d;
                        rlast_q   <= r_last;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (rvalid_q && rready) begin
                        if (rlast_q) begin
                            r_state_q <= R_IDLE;
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                        end else begin
                            raddr_q <= r_next;
                            rcnt_q  <= rcnt_q + 8'd1;
                            rdata_q <= rdata_d;
                            rresp_q <= rresp_d;
                            rlast_q <= r_last;
                        end
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    // Write beat qualification
    always_comb begin
        w_hs       = (w_state_q == W_DATA) && wvalid && wready_q;
        w_beat_err = w_oor || wover_q || (wlast && !w_last);
        mem_we     = w_hs && !wberr_q && !w_oor && !wover_q;
    end

    // Write FSM: accept AW, consume W beats, return B with accumulated status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            wcnt_q    <= '0;
            wover_q   <= 1'b0;
            wberr_q   <= 1'b0;
            werr_q    <= 1'b0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (awvalid && awready_q) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_state_q <= W_DATA;
                        waddr_q   <= awaddr;
                        wlen_q    <= awlen;
                        wsize_q   <= awsize;
                        wburst_q  <= awburst;
                        wcnt_q    <= 8'd0;
                        wover_q   <= 1'b0;
                        wberr_q   <= w_burst_err;
                        werr_q    <= w_burst_err;
                        bid_q     <= awid;
                    end else begin
                        awready_q <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        werr_q <= werr_q | w_beat_err;
                        if (!wover_q) begin
                            waddr_q <= w_next;
                            wcnt_q  <= wcnt_q + 8'd1;
                            if (w_last && !wlast) begin
                                wover_q <= 1'b1;
                            end
                        end
                        if (wlast) begin
                            wready_q  <= 1'b0;
                            bvalid_q  <= 1'b1;
                            bresp_q   <= (werr_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                            w_state_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // Byte-lane memory write; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (wstrb[i]) begin
                    mem[w_idx][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rid     = rid_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bid     = bid_q;
    assign bresp   = bresp_q;

endmodule

// File: tb/tb_axi_full_s3.sv
// Directed bench for axi_full_s3: table of bursts plus backpressure and reset sequences.
// Latency: drives at the falling edge, samples at the falling edge.
// Backpressure: rready is held low for several cycles in one sequence.
module tb_axi_full_s3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] araddr = '0;
    logic [3:0]  arid = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [63:0] rdata;
    logic [3:0]  rid;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] awaddr = '0;
    logic [3:0]  awid = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;

    axi_full_s3 dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             is_wr;
        logic [31:0]      addr;
        logic [3:0]       id;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        int               nb;     // W beats driven (writes)
        logic [7:0]       strb;
        logic [3:0][63:0] dat;    // write data, or expected read data
        logic [1:0]       resp;   // expected bresp
        logic [3:0][1:0]  rr;     // expected rresp per read beat
    } vec_t;

    vec_t tbl[$];
    int   nvec = 0;
    int   nerr = 0;
    localparam int TMO = 50;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        nvec++;
        nerr++;
        $display("FAIL %s: timeout after %0d cycles", nm, TMO);
    endtask

    function automatic vec_t mk_wr(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                                   input logic [2:0] sz, input logic [1:0] bu, input int nb,
                                   input logic [7:0] st, input logic [63:0] d0, input logic [63:0] d1,
                                   input logic [1:0] rsp);
        vec_t v;
        v.is_wr = 1'b1; v.addr = a; v.id = id; v.len = len; v.size = sz; v.burst = bu;
        v.nb = nb; v.strb = st; v.dat = {64'd0, 64'd0, d1, d0}; v.resp = rsp; v.rr = '0;
        return v;
    endfunction

    function automatic vec_t mk_rd(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                                   input logic [2:0] sz, input logic [1:0] bu,
                                   input logic [3:0][63:0] d, input logic [3:0][1:0] rr);
        vec_t v;
        v.is_wr = 1'b0; v.addr = a; v.id = id; v.len = len; v.size = sz; v.burst = bu;
        v.nb = 0; v.strb = '0; v.dat = d; v.resp = '0; v.rr = rr;
        return v;
    endfunction

    task automatic do_write(input int vi, input vec_t v);
        int n;
        awaddr = v.addr; awid = v.id; awlen = v.len; awsize = v.size; awburst = v.burst;
        awvalid = 1'b1;
        n = 0;
        while (awready !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) tmo($sformatf("v%0d awready", vi));
        @(negedge clk);
        awvalid = 1'b0;
        for (int b = 0; b < v.nb; b++) begin
            wdata = v.dat[b]; wstrb = v.strb; wlast = (b == v.nb - 1); wvalid = 1'b1;
            n = 0;
            while (wready !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
            if (n >= TMO) tmo($sformatf("v%0d wready beat %0d", vi, b));
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1;
        n = 0;
        while (bvalid !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) tmo($sformatf("v%0d bvalid", vi));
        chk($sformatf("v%0d bresp", vi), 64'(bresp), 64'(v.resp));
        chk($sformatf("v%0d bid", vi), 64'(bid), 64'(v.id));
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic issue_ar(input string nm, input logic [31:0] a, input logic [3:0] id,
                            input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bu);
        int n;
        araddr = a; arid = id; arlen = len; arsize = sz; arburst = bu; arvalid = 1'b1;
        n = 0;
        while (arready !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) tmo($sformatf("%s arready", nm));
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic do_read(input int vi, input vec_t v);
        int n;
        issue_ar($sformatf("v%0d", vi), v.addr, v.id, v.len, v.size, v.burst);
        rready = 1'b1;
        for (int b = 0; b <= int'(v.len); b++) begin
            n = 0;
            while (rvalid !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
            if (n >= TMO) tmo($sformatf("v%0d rvalid beat %0d", vi, b));
            chk($sformatf("v%0d rdata beat %0d", vi, b), rdata, v.dat[b]);
            chk($sformatf("v%0d rid beat %0d", vi, b), 64'(rid), 64'(v.id));
            chk($sformatf("v%0d rresp beat %0d", vi, b), 64'(rresp), 64'(v.rr[b]));
            chk($sformatf("v%0d rlast beat %0d", vi, b), 64'(rlast), 64'(b == int'(v.len)));
            @(negedge clk);
        end
        rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   n;
        int   beats;
        logic got_last;
        vec_t v;

        // INCR write and readback, ID echo
        tbl.push_back(mk_wr(32'h8000_0000, 4'd5, 8'd3, 3'd3, 2'b01, 4, 8'hFF, 64'd1, 64'd2, 2'b00));
        tbl[0].dat = {64'd4, 64'd3, 64'd2, 64'd1};
        tbl.push_back(mk_rd(32'h8000_0000, 4'd9, 8'd3, 3'd3, 2'b01, {64'd4, 64'd3, 64'd2, 64'd1}, '0));
        // byte strobes
        tbl.push_back(mk_wr(32'h8000_0000, 4'd1, 8'd0, 3'd3, 2'b01, 1, 8'hFF, 64'd0, 64'd0, 2'b00));
        tbl.push_back(mk_wr(32'h8000_0000, 4'd2, 8'd0, 3'd3, 2'b01, 1, 8'h0F,
                            64'h1122_3344_5566_7788, 64'd0, 2'b00));
        tbl.push_back(mk_rd(32'h8000_0000, 4'd3, 8'd0, 3'd3, 2'b01, {192'd0, 64'h5566_7788}, '0));
        // below base, oversize write
        tbl.push_back(mk_rd(32'h7FFF_FFF8, 4'd4, 8'd0, 3'd3, 2'b01, '0, {6'd0, 2'b10}));
        tbl.push_back(mk_wr(32'h8000_0008, 4'd6, 8'd0, 3'd4, 2'b01, 1, 8'hFF, 64'hDEAD, 64'd0, 2'b10));
        tbl.push_back(mk_rd(32'h8000_0008, 4'd7, 8'd0, 3'd3, 2'b01, {192'd0, 64'd2}, '0));
        // WRAP
`ifdef AXI_S3_WRAP_EN
        tbl.push_back(mk_rd(32'h8000_0010, 4'd8, 8'd3, 3'd3, 2'b10,
                            {64'd2, 64'h5566_7788, 64'd4, 64'd3}, '0));
`else
        tbl.push_back(mk_rd(32'h8000_0010, 4'd8, 8'd3, 3'd3, 2'b10, '0, {2'b10, 2'b10, 2'b10, 2'b10}));
`endif
        // top of memory: second beat out of range
        tbl.push_back(mk_wr(32'h8000_1FF8, 4'd10, 8'd1, 3'd3, 2'b01, 2, 8'hFF, 64'hAA, 64'hBB, 2'b10));
        tbl.push_back(mk_rd(32'h8000_1FF8, 4'd11, 8'd1, 3'd3, 2'b01, {128'd0, 64'd0, 64'hAA},
                            {4'd0, 2'b10, 2'b00}));
        // FIXED
        tbl.push_back(mk_wr(32'h8000_0020, 4'd12, 8'd1, 3'd3, 2'b00, 2, 8'hFF, 64'h11, 64'h22, 2'b00));
        tbl.push_back(mk_rd(32'h8000_0020, 4'd13, 8'd1, 3'd3, 2'b00, {128'd0, 64'h22, 64'h22}, '0));
        // narrow INCR stays in word 0
        tbl.push_back(mk_rd(32'h8000_0000, 4'd14, 8'd1, 3'd2, 2'b01,
                            {128'd0, 64'h5566_7788, 64'h5566_7788}, '0));
        // reserved burst type
        tbl.push_back(mk_rd(32'h8000_0000, 4'd15, 8'd1, 3'd3, 2'b11, '0, {4'd0, 2'b10, 2'b10}));
        // wlast protocol errors
        tbl.push_back(mk_wr(32'h8000_0040, 4'd1, 8'd0, 3'd3, 2'b01, 1, 8'hFF, 64'h5A, 64'd0, 2'b00));
        tbl.push_back(mk_wr(32'h8000_0030, 4'd2, 8'd1, 3'd3, 2'b01, 1, 8'hFF, 64'h77, 64'd0, 2'b10));
        tbl.push_back(mk_wr(32'h8000_0038, 4'd3, 8'd0, 3'd3, 2'b01, 2, 8'hFF, 64'h99, 64'h88, 2'b10));
        tbl.push_back(mk_rd(32'h8000_0030, 4'd4, 8'd2, 3'd3, 2'b01, {64'd0, 64'h5A, 64'h99, 64'h77}, '0));
        // index == MEM_DEPTH
        tbl.push_back(mk_rd(32'h8000_2000, 4'd5, 8'd0, 3'd3, 2'b01, '0, {6'd0, 2'b10}));

        // reset state
        repeat (2) @(negedge clk);
        chk("reset arready", 64'(arready), 64'd0);
        chk("reset awready", 64'(awready), 64'd0);
        chk("reset rvalid", 64'(rvalid), 64'd0);
        chk("reset wready", 64'(wready), 64'd0);
        chk("reset bvalid", 64'(bvalid), 64'd0);
        chk("reset rdata", rdata, 64'd0);
        rst = 1'b1;
        #1;
        chk("arready before first edge", 64'(arready), 64'd0);
        @(negedge clk);
        chk("arready after release", 64'(arready), 64'd1);
        chk("awready after release", 64'(awready), 64'd1);

        foreach (tbl[i]) begin
            if (tbl[i].is_wr) do_write(i, tbl[i]);
            else              do_read(i, tbl[i]);
        end

        // backpressure on the second beat
        issue_ar("bp", 32'h8000_0000, 4'd2, 8'd3, 3'd3, 2'b01);
        n = 0;
        while (rvalid !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) tmo("bp rvalid");
        chk("bp beat0 rdata", rdata, 64'h5566_7788);
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        beats = 1;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("bp stall %0d rvalid", c), 64'(rvalid), 64'd1);
            chk($sformatf("bp stall %0d rdata", c), rdata, 64'd2);
            chk($sformatf("bp stall %0d rlast", c), 64'(rlast), 64'd0);
            if (c < 3) @(negedge clk);
        end
        rready = 1'b1;
        got_last = 1'b0;
        n = 0;
        while (!got_last && n < TMO) begin
            if (rvalid === 1'b1) begin
                beats++;
                got_last = rlast;
            end
            @(negedge clk);
            n++;
        end
        if (n >= TMO) tmo("bp rlast");
        rready = 1'b0;
        chk("bp total beats", 64'(beats), 64'd4);

        // reset in the middle of a read
        issue_ar("rst", 32'h8000_0000, 4'd3, 8'd3, 3'd3, 2'b01);
        rready = 1'b1;
        n = 0;
        while (rvalid !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) tmo("rst rvalid");
        @(negedge clk);
        rready = 1'b0;
        chk("pre-reset beat1 rdata", rdata, 64'd2);
        rst = 1'b0;
        #1;
        chk("mid-read reset rvalid", 64'(rvalid), 64'd0);
        chk("mid-read reset arready", 64'(arready), 64'd0);
        chk("mid-read reset rlast", 64'(rlast), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arready held until edge", 64'(arready), 64'd0);
        @(negedge clk);
        chk("arready after re-release", 64'(arready), 64'd1);
        v = mk_rd(32'h8000_0008, 4'd6, 8'd2, 3'd3, 2'b01, {64'd0, 64'd4, 64'd3, 64'd2}, '0);
        do_read(100, v);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/axi_full_s3.md
Name: axi_full_s3

Overview:
Parametrised AXI4 full slave with an internal word-addressed memory array. It is the generalised successor to the fixed 64-bit cache-port slave. It adds the following:
- configurable data, address and ID widths
- FIXED/INCR burst modes (WRAP optional)
- ID echo and real backpressure handling
- out-of-range and protocol-error responses

It sits behind the I/D-cache AXI master as the simulated main memory, or as a scratchpad on the interconnect.

Parameters:
DATA_W, 64, data bus width in bits; power of two, 32..128.
ADDR_W, 32, address width.
ID_W, 4, AXI ID width.
MEM_DEPTH, 1024, memory depth in DATA_W words; power of two.
BASE_ADDR, 32'h8000_0000, byte address of word 0.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low (0 = reset).
araddr/arid/arlen/arsize/arburst  in  ADDR_W/ID_W/8/3/2  read address channel payload.
arvalid in 1; arready out 1  read address handshake.
rdata/rid/rresp/rlast  out  DATA_W/ID_W/2/1  read data channel payload.
rvalid out 1; rready in 1  read data handshake.
awaddr/awid/awlen/awsize/awburst  in  ADDR_W/ID_W/8/3/2  write address channel payload.
awvalid in 1; awready out 1  write address handshake.
wdata/wstrb/wlast  in  DATA_W/DATA_W/8/1  write data channel payload.
wvalid in 1; wready out 1  write data handshake.
bid/bresp  out  ID_W/2  write response payload.
bvalid out 1; bready in 1  write response handshake.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs are 0.
  - Read and write FSMs go to IDLE; beat counters clear.
  - Memory contents are preserved.
  - arready and awready are registered; they go to 1 on the first clk edge after rst releases.
- Read FSM R_IDLE -> R_DATA -> R_IDLE:
  - arready=1 only in R_IDLE.
  - On the AR handshake, latch addr, id, len, size and burst; clear beat count; arready drops next cycle.
  - Latency: rvalid=1 in the cycle after the AR handshake, with rdata registered from the latched address.
  - While rvalid & !rready, rdata, rid, rresp and rlast are held stable.
  - On each R handshake, advance the address and count, then present the next beat in the next cycle (no bubble).
  - rlast=1 only while count==len.
  - The R handshake with rlast goes to R_IDLE; arready=1 in the following cycle.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - awready=1 only in W_IDLE; wready=1 only in W_DATA.
  - On each W handshake, write bytes where wstrb[i]=1 at the current address, then advance.
  - The W handshake with wlast goes to W_RESP.
  - In W_RESP, bvalid=1 and bid=latched awid; bvalid is held until bready, then the FSM goes to W_IDLE.
  - wlast arriving at count!=len, or count exceeding len without wlast: bresp=SLVERR. Beats beyond len are not written; the burst still ends on wlast.
- Address generation:
  - Word index = (addr - BASE_ADDR) >> log2(DATA_W/8).
  - FIXED: address unchanged. INCR: address += 2^size, width ADDR_W, wraps modulo 2^ADDR_W.
  - Narrow sizes return the full word; the master selects byte lanes.
- Errors (rresp/bresp = 2'b10 SLVERR, otherwise 2'b00 OKAY):
  - address < BASE_ADDR, or index >= MEM_DEPTH: per-beat error; read returns rdata=0; write is suppressed.
  - size > log2(DATA_W/8), or burst=2'b11: error for the whole burst; no memory access.
  - A write burst returns SLVERR if any beat erred.
- Read and write are fully independent and may run concurrently.
  - Same-word write and read in the same cycle: the read returns old data (read-before-write).

Optional Feature:
Macro AXI_S3_WRAP_EN.
- Defined: WRAP bursts (arburst/awburst=2'b10) are supported for len in {1,3,7,15}. Wrap boundary = (len+1)*2^size; the address wraps to the aligned boundary. An unaligned start address or an illegal len gives SLVERR for the whole burst.
- Undefined: WRAP is treated as an unsupported burst. All beats complete with SLVERR; no memory access.

Decomposition:
- Package axi_pkg: BURST_FIXED/INCR/WRAP, RESP_OKAY/SLVERR localparams, and the FSM state encodings for read and write.
- Sub-module axi_s3_addr_gen: combinational next-address, wrap and range-check logic, instantiated once each for the read and write paths.

Test Plan:
1. INCR write at 0x8000_0000, len=3, size=3, data 1,2,3,4, wstrb=0xFF, awid=5 -> bresp=00, bid=5. Read back with arid=9 -> 4 beats 1..4, rid=9, rlast only on beat 4.
2. Read len=3 with rready=0 for 3 cycles at beat 2 -> rvalid, rdata and rlast stay constant; beat 2 data=2; total beats=4.
3. Word 0 = 0; write 0x1122334455667788 with wstrb=0x0F -> read returns 0x0000_0000_5566_7788, bresp=00.
4. Read at 0x7FFF_FFF8, len=0 -> single beat, rresp=10, rdata=0, rlast=1. Write arsize=4 with DATA_W=64 -> bresp=10, memory unchanged.
5. WRAP read, len=3, size=3, start 0x8000_0010 -> with macro, beats from offsets 0x10, 0x18, 0x00, 0x08, rresp=00. Without macro -> 4 beats with rresp=10.
6. Assert rst mid-read at beat 2 -> rvalid=0 immediately. After release, arready=1 next edge and prior memory contents read back intact.
